// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multiply/divide helper blocks.
package arith_pkg;

    // Default operand width for the 4-bit arithmetic family.
    localparam int DEF_WIDTH = 4;

    // Result width of a WIDTH x WIDTH product (plus a WIDTH-bit addend).
    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

    localparam int RES_W = res_w(DEF_WIDTH);

    // Control states shared by the iterative multiplier and divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_n.sv
// Ripple-carry adder built from 1-bit full-adder cells; carry out is dropped.

module fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);
    // c[i] is the carry into bit i; the carry out of the top bit is never formed
    logic [N-1:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i < N - 1) begin : g_fa
            fa1 u_fa (
                .a (a[i]),
                .b (b[i]),
                .ci(c[i]),
                .s (sum[i]),
                .co(c[i+1])
            );
        end else begin : g_top
            // Top bit: sum only, any carry out of the result width is discarded.
            assign sum[i] = a[i] ^ b[i] ^ c[i];
        end
    end

endmodule

// File: rtl/mul_add_4.sv
// Sequential shift-and-add multiply-accumulate: y = q*b + r over WIDTH cycles.
// Inverse of the 4-bit divider, used to rebuild a dividend from q, b and r.
module mul_add_4
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   q,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   r,
    output logic [2*WIDTH-1:0] y,
    output logic               busy,
    output logic               done
);
    localparam int RW = res_w(WIDTH);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state, nxt;
    logic [RW-1:0]   acc;
    logic [RW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   sum;
    logic            accept;
    logic            last;

    // New operands are only taken when not iterating (IDLE or the DONE cycle).
    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);

    add_n #(.N(RW)) u_add (
        .a  (acc),
        .b  (mcand),
        .sum(sum)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                if (start) nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = start ? RUN : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, one shift-and-add step per RUN cycle,
    // y written only on the completing edge so partial sums never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            y      <= '0;
        end else if (accept) begin
            acc    <= RW'(r);
            mcand  <= RW'(b);
            mplier <= q;
            cnt    <= '0;
        end else if (state == RUN) begin
            if (mplier[0]) acc <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last) y <= mplier[0] ? sum : acc;
        end
    end

endmodule

// File: tb/tb_mul_add_4.sv
// Directed and exhaustive bench for mul_add_4 with a result scoreboard.
module tb_mul_add_4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] q = '0, b = '0, r = '0;
    logic [7:0] y;
    logic       busy, done;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    mul_add_4 dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .q    (q),
        .b    (b),
        .r    (r),
        .y    (y),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else                   chk("y", {24'd0, y}, {24'd0, exp_q.pop_front()});
        end
    end

    // Called at a negedge while the block can accept; returns at the negedge after the accept edge.
    task automatic issue(input logic [3:0] qi, input logic [3:0] bi, input logic [3:0] ri,
                         input logic [7:0] expv);
        q = qi; b = bi; r = ri; start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; returns the number of negedges waited.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int n;
        int dc;
        // Reset state
        #2;
        chk("rst_y", {24'd0, y}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic: 13*3+1 = 40, busy for 4 cycles then one done cycle
        issue(4'd13, 4'd3, 4'd1, 8'd40);
        for (int i = 0; i < 4; i++) begin
            chk("basic_busy", {31'd0, busy}, 1);
            chk("basic_nodone", {31'd0, done}, 0);
            chk("basic_y_hidden", {24'd0, y}, 0);
            @(negedge clk);
        end
        chk("basic_done", {31'd0, done}, 1);
        chk("basic_busy_low", {31'd0, busy}, 0);
        @(negedge clk);
        chk("basic_done_pulse", {31'd0, done}, 0);
        chk("basic_y_hold", {24'd0, y}, 40);

        // Maximum and zero-multiplier cases
        issue(4'd15, 4'd15, 4'd14, 8'd239);
        wait_done("max", n);
        chk("max_latency", n, 4);
        @(negedge clk);
        issue(4'd0, 4'd9, 4'd5, 8'd5);
        wait_done("q0", n);
        chk("q0_latency", n, 4);
        @(negedge clk);

        // Start during RUN is ignored
        dc = done_cnt;
        issue(4'd6, 4'd7, 4'd0, 8'd42);
        q = 4'd1; b = 4'd1; r = 4'd1; start = 1'b1;   // RUN cycle 2
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", n);
        repeat (10) @(negedge clk);
        chk("ign_single_done", done_cnt - dc, 1);
        chk("ign_y", {24'd0, y}, 42);

        // Back-to-back: restart during the done cycle
        issue(4'd13, 4'd3, 4'd1, 8'd40);
        wait_done("b2b_first", n);
        q = 4'd2; b = 4'd5; r = 4'd3; start = 1'b1;
        exp_q.push_back(8'd13);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 1);
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency", n, 5);
        chk("b2b_y", {24'd0, y}, 13);
        @(negedge clk);

        // Reset mid-operation aborts with no done pulse
        issue(4'd6, 4'd7, 4'd0, 8'd42);
        rst = 1'b1;   // RUN cycle 2
        #1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_y", {24'd0, y}, 0);
        exp_q.delete();
        dc = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst_no_done", done_cnt - dc, 0);
        chk("midrst_y_hold", {24'd0, y}, 0);
        issue(4'd13, 4'd3, 4'd1, 8'd40);
        wait_done("after_rst", n);
        chk("after_rst_latency", n, 4);
        @(negedge clk);

        // Exhaustive q*b+r, back-to-back through the done cycle
        for (int qi = 0; qi < 16; qi++)
            for (int bi = 0; bi < 16; bi++)
                for (int ri = 0; ri < 16; ri++) begin
                    issue(4'(qi), 4'(bi), 4'(ri), 8'(qi * bi + ri));
                    wait_done("exh", n);
                end
        @(negedge clk);

        // Divider round-trip: rebuild a from a/b and a%b
        for (int a = 0; a < 16; a++)
            for (int bi = 1; bi < 16; bi++) begin
                issue(4'(a / bi), 4'(bi), 4'(a % bi), 8'(a));
                wait_done("rt", n);
            end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_add_4.md
# mul_add_4

Sequential shift-and-add multiply-accumulate block that computes y = q·b + r. It is the inverse of the 4-bit divider: given a quotient, divisor and remainder, it rebuilds the dividend. It sits beside the divider so a datapath or self-check loop can round-trip a division result. Each operation uses a start/busy/done handshake and takes a fixed WIDTH iteration cycles.

## Interface
- WIDTH, 4, operand width in bits; result width is 2·WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- q  input  WIDTH  multiplier (quotient); sampled on the accepted start edge.
- b  input  WIDTH  multiplicand (divisor); sampled on the accepted start edge.
- r  input  WIDTH  addend (remainder); sampled on the accepted start edge.
- y  output  2·WIDTH  result; registered; holds its value until the next completion.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; y is valid in that cycle.

## Operation
- Internal registers:
  - acc: 2·WIDTH bits.
  - mcand: 2·WIDTH bits, the shifted b.
  - mplier: WIDTH bits, the shifted q.
  - cnt: counts 0..WIDTH-1.
  - state.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept: start=1 at an edge while in IDLE or DONE. On that edge:
  - acc←zero-extended r, mcand←zero-extended b, mplier←q, cnt←0.
  - State goes to RUN.
- RUN, each edge:
  - If mplier[0]=1, acc←acc+mcand (2·WIDTH-bit add, carry discarded).
  - mcand←mcand<<1, mplier←mplier>>1, cnt←cnt+1.
  - When cnt=WIDTH-1, the same edge writes the final acc to y and moves state to DONE.
- DONE lasts one cycle:
  - Next state is RUN if start=1 (back-to-back accept), else IDLE.
- Width rule: the maximum result (2^W−1)^2+(2^W−1)=2^(2W)−2^W fits in 2·WIDTH bits. No overflow is possible and no flag is needed.
- start while busy=1: ignored. Operands are not re-sampled and the in-flight result is unaffected.
- No early termination: q=0 or b=0 still takes WIDTH cycles.

## Timing
- Reset (asynchronous, immediate): state=IDLE; y=0, busy=0, done=0; acc, mcand, mplier and cnt all 0.
- Reset mid-operation aborts. No done pulse is generated and y reads 0.
- Deassertion is synchronized externally. The first start is accepted at the first clock edge after rst falls.
- Latency: start accepted at edge k.
  - busy=1 after edge k through edge k+WIDTH.
  - At edge k+WIDTH, y is updated and done=1, held until edge k+WIDTH+1.
  - Issue interval is WIDTH+1 cycles. With back-to-back issue, busy returns high right after the done cycle.
- y changes only on the completing edge (and on reset). It is never exposed mid-iteration.
- Inputs q, b, r may change freely after the accept edge.

## Structure
- Shared package arith_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - a RES_W = 2·WIDTH helper.
- One sub-module, add_n: a parameterized ripple-carry adder (N=2·WIDTH) built from 1-bit full-adder cells, in keeping with the structural arithmetic style of the divider. The control FSM and shift registers stay in mul_add_4.

## Test plan
- Basic:
  - q=13, b=3, r=1, start pulse → busy high 4 cycles, then done=1 for 1 cycle, y=40 (0x28). This round-trips div(40,3).
- Maximum:
  - q=15, b=15, r=14 → y=239 (0xEF).
  - q=0, b=9, r=5 → y=5 after the full 4 cycles.
- Ignored start:
  - Start q=6, b=7, r=0; pulse start again with q=1, b=1, r=1 on RUN cycle 2.
  - → single done, y=42, no second operation.
- Back-to-back:
  - Hold start=1 during the done cycle with q=2, b=5, r=3.
  - → first y appears, busy rises the next cycle, second done 5 cycles later with y=13.
- Reset mid-op:
  - Assert rst on RUN cycle 2.
  - → busy=0, done=0 and y=0 immediately, no done pulse afterward.
  - A fresh start then completes normally.
- Exhaustive:
  - All 4096 (q, b, r) combinations checked against q·b+r.
  - Also check the divider round-trip: for all a and for b≠0, the block's result equals a.
